// File: rtl/fsk2_pkg.sv
// ============================================================================
//  Module      : fsk2_pkg
//  Description : Shared state encoding and default timing constants for the
//                two-requester FSK transmit scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsk2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } fsk2_state_e;

    localparam int c_bit_cycles = 50;
    localparam int c_word_bits  = 16;
    localparam int c_gap_cycles = 20;

endpackage

`default_nettype wire

// File: rtl/fsk2_rr_arb2.sv
// ============================================================================
//  Module      : fsk2_rr_arb2
//  Description : Two-way round-robin arbiter; on contention the requester
//                that did not win last time is granted (one-hot output).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk2_rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fsk2_tx_sched.sv
// ============================================================================
//  Module      : fsk2_tx_sched
//  Description : Accepts frame words from two requesters, presents them to
//                the fsk2 modulator and paces SEND/GAP timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk2_tx_sched
    import fsk2_pkg::*;
#(
    parameter int BIT_CYCLES = c_bit_cycles,
    parameter int WORD_BITS  = c_word_bits,
    parameter int GAP_CYCLES = c_gap_cycles
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 req0_valid,
    input  logic [WORD_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WORD_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic [WORD_BITS-1:0] fsk_data,
    output logic                 fsk_load,
    output logic                 busy,
    output logic [4:0]           bit_idx,
    output logic                 grant_id,
    output logic [7:0]           frame_cnt
);

    localparam int c_bcw = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int c_gcw = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_bcw-1:0] c_bit_last  = c_bcw'(BIT_CYCLES - 1);
    localparam logic [c_gcw-1:0] c_gap_last  = c_gcw'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [4:0]       c_word_last = 5'(WORD_BITS - 1);

    fsk2_state_e          r_state;
    fsk2_state_e          w_state_nxt;
    logic [c_bcw-1:0]     r_cyc_cnt;
    logic [c_gcw-1:0]     r_gap_cnt;
    logic [4:0]           r_bit_idx;
    logic [WORD_BITS-1:0] r_fsk_data;
    logic                 r_fsk_load;
    logic                 r_grant_id;
    logic                 r_last;
    logic [7:0]           r_frame_cnt;
    logic [1:0]           w_grant;
    logic                 w_idle_ok;
    logic                 w_accept;
    logic                 w_send_done;
    logic                 w_gap_done;
    logic [WORD_BITS-1:0] w_sel_data;

    fsk2_rr_arb2 u_arb (
        .i_valid ({req1_valid, req0_valid}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // Readies are masked by reset so nothing is handshaken while held in reset.
    assign w_idle_ok   = (r_state == ST_IDLE) && sys_rst_n;
    assign req0_ready  = w_idle_ok && w_grant[0];
    assign req1_ready  = w_idle_ok && w_grant[1];
    assign w_accept    = req0_ready || req1_ready;
    assign w_sel_data  = w_grant[1] ? req1_data : req0_data;
    assign w_send_done = (r_state == ST_SEND) && (r_cyc_cnt == c_bit_last)
                         && (r_bit_idx == c_word_last);
    assign w_gap_done  = (r_state == ST_GAP) && (r_gap_cnt == c_gap_last);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_SEND;
            ST_SEND: if (w_send_done) w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (w_gap_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cyc_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_bit_idx   <= '0;
            r_fsk_data  <= '0;
            r_fsk_load  <= 1'b0;
            r_grant_id  <= 1'b0;
            r_last      <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_fsk_load <= w_accept;
            if (w_accept) begin
                r_fsk_data  <= w_sel_data;
                r_grant_id  <= w_grant[1];
                r_last      <= w_grant[1];
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            // Bit pacing runs only inside SEND; any exit clears it to zero.
            if ((r_state == ST_SEND) && !w_send_done) begin
                if (r_cyc_cnt == c_bit_last) begin
                    r_cyc_cnt <= '0;
                    r_bit_idx <= r_bit_idx + 5'd1;
                end else begin
                    r_cyc_cnt <= r_cyc_cnt + 1'b1;
                end
            end else begin
                r_cyc_cnt <= '0;
                r_bit_idx <= '0;
            end
            if ((r_state == ST_GAP) && !w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign fsk_data  = r_fsk_data;
    assign fsk_load  = r_fsk_load;
    assign busy      = (r_state != ST_IDLE);
    assign bit_idx   = r_bit_idx;
    assign grant_id  = r_grant_id;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fsk2_tx_sched.sv
// ============================================================================
//  Module      : tb_fsk2_tx_sched
//  Description : Directed vector bench for fsk2_tx_sched, default timing plus
//                gap-less and short-frame variants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsk2_tx_sched;

    logic        clk;
    logic        rst_n;
    logic        r0v, r1v;
    logic [15:0] r0d, r1d;
    logic        rdy0, rdy1;
    logic [15:0] fdata;
    logic        fload, fbusy, fgid;
    logic [4:0]  fbit;
    logic [7:0]  fcnt;

    // gap-less default-size instance and short-frame instance share one requester
    logic        bc_v;
    logic [15:0] bc_d;
    logic        b_rdy0, b_rdy1, b_load, b_busy, b_gid;
    logic [15:0] b_data;
    logic [4:0]  b_bit;
    logic [7:0]  b_cnt;
    logic        c_rdy0, c_rdy1, c_load, c_busy, c_gid;
    logic [3:0]  c_data;
    logic [4:0]  c_bit;
    logic [7:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    fsk2_tx_sched dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(rdy0),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(rdy1),
        .fsk_data(fdata), .fsk_load(fload), .busy(fbusy),
        .bit_idx(fbit), .grant_id(fgid), .frame_cnt(fcnt)
    );

    fsk2_tx_sched #(.BIT_CYCLES(50), .WORD_BITS(16), .GAP_CYCLES(0)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req0_valid(bc_v), .req0_data(bc_d), .req0_ready(b_rdy0),
        .req1_valid(1'b0), .req1_data(16'h0000), .req1_ready(b_rdy1),
        .fsk_data(b_data), .fsk_load(b_load), .busy(b_busy),
        .bit_idx(b_bit), .grant_id(b_gid), .frame_cnt(b_cnt)
    );

    fsk2_tx_sched #(.BIT_CYCLES(2), .WORD_BITS(4), .GAP_CYCLES(0)) dut_c (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req0_valid(bc_v), .req0_data(bc_d[3:0]), .req0_ready(c_rdy0),
        .req1_valid(1'b0), .req1_data(4'h0), .req1_ready(c_rdy1),
        .fsk_data(c_data), .fsk_load(c_load), .busy(c_busy),
        .bit_idx(c_bit), .grant_id(c_gid), .frame_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        int          n;
        logic [15:0] e_data;
        logic        e_load;
        logic        e_busy;
        logic [4:0]  e_bit;
        logic        e_gid;
        logic [7:0]  e_cnt;
        logic        e_rdy0;
        logic        e_rdy1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1,
                       input int n, input logic [15:0] e_data, input logic e_load, input logic e_busy,
                       input logic [4:0] e_bit, input logic e_gid, input logic [7:0] e_cnt,
                       input logic e_rdy0, input logic e_rdy1);
        vec_t v;
        v = '{v0, d0, v1, d1, n, e_data, e_load, e_busy, e_bit, e_gid, e_cnt, e_rdy0, e_rdy1};
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_data, input logic e_load,
                             input logic e_busy, input logic [4:0] e_bit, input logic e_gid,
                             input logic [7:0] e_cnt, input logic e_rdy0, input logic e_rdy1);
        check({tag, ".data"}, 32'(fdata), 32'(e_data));
        check({tag, ".load"}, 32'(fload), 32'(e_load));
        check({tag, ".busy"}, 32'(fbusy), 32'(e_busy));
        check({tag, ".bit"},  32'(fbit),  32'(e_bit));
        check({tag, ".gid"},  32'(fgid),  32'(e_gid));
        check({tag, ".cnt"},  32'(fcnt),  32'(e_cnt));
        check({tag, ".rdy0"}, 32'(rdy0),  32'(e_rdy0));
        check({tag, ".rdy1"}, 32'(rdy1),  32'(e_rdy1));
    endtask

    initial begin
        int b_first;
        int b_second;
        int c_loads;

        rst_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0; r0d = 16'h0; r1d = 16'h0;
        bc_v = 1'b0; bc_d = 16'h1234;

        // single word, then contention alternating 1,0,1, then a late requester
        add(1, 16'hFEC8, 0, 16'h0000,   0, 16'h0000, 0, 0,  0, 0, 8'd0, 1, 0);
        add(1, 16'hFEC8, 0, 16'h0000,   1, 16'hFEC8, 1, 1,  0, 0, 8'd1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000,   1, 16'hFEC8, 0, 1,  0, 0, 8'd1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 749, 16'hFEC8, 0, 1, 15, 0, 8'd1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000,  49, 16'hFEC8, 0, 1, 15, 0, 8'd1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000,   1, 16'hFEC8, 0, 1,  0, 0, 8'd1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000,  19, 16'hFEC8, 0, 1,  0, 0, 8'd1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000,   1, 16'hFEC8, 0, 0,  0, 0, 8'd1, 0, 0);
        add(1, 16'h7EF0, 1, 16'hAAAA,   0, 16'hFEC8, 0, 0,  0, 0, 8'd1, 0, 1);
        add(1, 16'h7EF0, 1, 16'hAAAA,   1, 16'hAAAA, 1, 1,  0, 1, 8'd2, 0, 0);
        add(1, 16'h7EF0, 1, 16'hAAAA, 820, 16'hAAAA, 0, 0,  0, 1, 8'd2, 1, 0);
        add(1, 16'h7EF0, 1, 16'hAAAA,   1, 16'h7EF0, 1, 1,  0, 0, 8'd3, 0, 0);
        add(1, 16'h7EF0, 1, 16'hAAAA, 820, 16'h7EF0, 0, 0,  0, 0, 8'd3, 0, 1);
        add(1, 16'h7EF0, 1, 16'hAAAA,   1, 16'hAAAA, 1, 1,  0, 1, 8'd4, 0, 0);
        add(0, 16'h0000, 1, 16'h5555, 400, 16'hAAAA, 0, 1,  8, 1, 8'd4, 0, 0);
        add(0, 16'h0000, 1, 16'h5555, 420, 16'hAAAA, 0, 0,  0, 1, 8'd4, 0, 1);
        add(0, 16'h0000, 1, 16'h5555,   1, 16'h5555, 1, 1,  0, 1, 8'd5, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold", 16'h0000, 0, 0, 0, 0, 8'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_idle", 16'h0000, 0, 0, 0, 0, 8'd0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            r0v = vecs[i].v0; r0d = vecs[i].d0;
            r1v = vecs[i].v1; r1d = vecs[i].d1;
            if (vecs[i].n > 0) begin
                repeat (vecs[i].n) @(posedge clk);
            end
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_load, vecs[i].e_busy,
                      vecs[i].e_bit, vecs[i].e_gid, vecs[i].e_cnt, vecs[i].e_rdy0, vecs[i].e_rdy1);
        end

        // mid-frame reset: state at T+400 of the 5555 frame, then async reset
        r0v = 1'b0; r1v = 1'b0;
        repeat (399) @(posedge clk);
        #1;
        check("mid.busy", 32'(fbusy), 32'd1);
        check("mid.bit", 32'(fbit), 32'd7);
        r0v = 1'b1; r0d = 16'h7EF0; r1v = 1'b1; r1d = 16'hAAAA;
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 0, 0, 0, 0, 8'd0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_all("post_rst", 16'h0000, 0, 0, 0, 0, 8'd0, 1, 0);
        @(posedge clk);
        #1;
        check_all("rr_first", 16'h7EF0, 1, 1, 0, 0, 8'd1, 0, 0);
        repeat (820) @(posedge clk);
        #1;
        check_all("rr_idle", 16'h7EF0, 0, 0, 0, 0, 8'd1, 0, 1);
        @(posedge clk);
        #1;
        check_all("rr_second", 16'hAAAA, 1, 1, 0, 1, 8'd2, 0, 0);
        r0v = 1'b0; r1v = 1'b0;

        // gap-less spacing and frame counter wrap
        b_first = -1; b_second = -1; c_loads = 0;
        bc_v = 1'b1;
        for (int cyc = 0; cyc < 3000 && !(b_second >= 0 && c_loads >= 257); cyc++) begin
            @(posedge clk);
            #1;
            if (b_load) begin
                if (b_first < 0) b_first = cyc;
                else if (b_second < 0) b_second = cyc;
            end
            if (c_load) begin
                c_loads++;
                if (c_loads == 256) check("c_wrap0", 32'(c_cnt), 32'd0);
                if (c_loads == 257) check("c_wrap1", 32'(c_cnt), 32'd1);
            end
        end
        bc_v = 1'b0;
        check("c_loads", 32'(c_loads), 32'd257);
        check("b_data", 32'(b_data), 32'h1234);
        if (b_second < 0) begin
            check("b_timeout", 32'(b_second), 32'd801);
        end else begin
            check("b_spacing", 32'(b_second - b_first), 32'd801);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
